// File: rtl/tns_enc_seq_pkg.sv
// tns_enc_seq_pkg: TNS code constants and state encoding shared by the encoder and the decoders
package tns_enc_seq_pkg;
  localparam int TNS_N = 6;
  localparam int TNS_DW = 6;
  localparam int TNS_WW = 6;
  localparam logic [TNS_N*TNS_WW-1:0] TNS_WEIGHTS = {6'd13, 6'd8, 6'd5, 6'd3, 6'd2, 6'd1};
  localparam int TNS_MAXVAL = 32;
  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
endpackage

// File: rtl/tns_enc_seq_if.sv
// tns_enc_seq_if: valid/ready data-in and code-out handshakes of the TNS encoder
interface tns_enc_seq_if import tns_enc_seq_pkg::*; #(
  parameter int N = TNS_N,
  parameter int DW = TNS_DW
);
  logic in_valid;
  logic in_ready;
  logic [DW-1:0] data_in;
  logic out_valid;
  logic out_ready;
  logic [N-1:0] code_out;
  logic err_out;
  modport master (output in_valid, data_in, out_ready, input in_ready, out_valid, code_out, err_out);
  modport slave (input in_valid, data_in, out_ready, output in_ready, out_valid, code_out, err_out);
endinterface

// File: rtl/tns_enc_step.sv
// tns_enc_step: one greedy compare-subtract stage of the TNS encoder
module tns_enc_step #(
  parameter int DW = 6,
  parameter int WW = 6
) (
  input  logic [DW-1:0] rem,
  input  logic [WW-1:0] weight,
  output logic          b,
  output logic [DW-1:0] rem_nx
);
  logic [DW-1:0] w;
  assign w = DW'(weight);
  assign b = rem >= w;
  assign rem_nx = b ? rem - w : rem;
endmodule

// File: rtl/tns_enc_seq.sv
// tns_enc_seq: sequential greedy TNS encoder, one code bit per cycle, largest weight first
module tns_enc_seq import tns_enc_seq_pkg::*; #(
  parameter int N = TNS_N,
  parameter int DW = TNS_DW,
  parameter int WW = TNS_WW,
  parameter logic [N*WW-1:0] WEIGHTS = TNS_WEIGHTS,
  parameter int MAXVAL = TNS_MAXVAL
) (
  input logic clk,
  input logic rst_n,
  tns_enc_seq_if.slave bus
);
  localparam int IW = N > 1 ? $clog2(N) : 1;
  state_t state, state_nx;
  logic [DW-1:0] rem, rem_nx;
  logic [IW-1:0] idx;
  logic [N-1:0] code;
  logic [WW-1:0] w;
  logic err, b;
  assign w = WEIGHTS[int'(idx)*WW +: WW];
  tns_enc_step #(.DW(DW), .WW(WW)) u_step (.rem(rem), .weight(w), .b(b), .rem_nx(rem_nx));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == IDLE ? (bus.in_valid ? CONV : IDLE) :
               state == CONV ? (idx == '0 ? DONE : CONV) :
               (bus.out_ready ? IDLE : DONE);
  // in_ready is held low for the whole time reset is asserted
  always_comb begin
    bus.in_ready = rst_n && state == IDLE;
    bus.out_valid = state == DONE;
    bus.code_out = code;
    bus.err_out = err;
  end
  // out-of-range input saturates every bit instead of running the greedy rule
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rem <= '0;
      idx <= '0;
      code <= '0;
      err <= 1'b0;
    end else if (state == IDLE && bus.in_valid) begin
      rem <= bus.data_in;
      err <= int'(bus.data_in) > MAXVAL;
      idx <= IW'(N - 1);
      code <= '0;
    end else if (state == CONV) begin
      code[idx] <= err | b;
      if (!err) rem <= rem_nx;
      if (idx != '0) idx <= idx - 1'b1;
    end
endmodule

// File: tb/tb_tns_enc_seq.sv
// tb_tns_enc_seq: randomized and directed checks of tns_enc_seq against a greedy reference model
module tb_tns_enc_seq;
  logic clk, rst_n;
  int checks = 0, errors = 0;
  int wts[6] = '{13, 8, 5, 3, 2, 1};
  tns_enc_seq_if bus ();
  tns_enc_seq dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [6:0] model(input int d);
    int r = d;
    logic [5:0] c = '0;
    if (d > 32) return {1'b1, 6'h3f};
    for (int i = 0; i < 6; i++)
      if (r >= wts[i]) begin
        c[5-i] = 1'b1;
        r -= wts[i];
      end
    return {1'b0, c};
  endfunction
  function automatic int decode(input logic [5:0] c);
    int s = 0;
    for (int i = 0; i < 6; i++) if (c[5-i]) s += wts[i];
    return s;
  endfunction
  task automatic encode(input int d, input int hold, input bit spur, output logic [5:0] c, output logic e);
    int lat = 0;
    bit busy_ok = 1'b1;
    logic [6:0] m = model(d);
    logic [5:0] dv = 6'(d);
    @(negedge clk);
    check("idle_ready", bus.in_ready, 1);
    bus.data_in = dv;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = spur;
    if (spur) bus.data_in = ~dv;
    while (!bus.out_valid && lat < 20) begin
      if (bus.in_ready) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    check("latency", lat, 6);
    check("busy_ready", busy_ok, 1);
    c = bus.code_out;
    e = bus.err_out;
    check("code", c, m[5:0]);
    check("err", e, m[6]);
    repeat (hold) begin
      @(negedge clk);
      check("hold", {bus.out_valid, bus.in_ready, bus.err_out, bus.code_out}, {1'b1, 1'b0, e, c});
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("release", {bus.out_valid, bus.in_ready}, 2'b01);
  endtask
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
  initial begin
    logic [5:0] c;
    logic e;
    int dir_d[5] = '{12, 20, 0, 32, 33};
    logic [5:0] dir_c[5] = '{6'b010101, 6'b101010, 6'b000000, 6'b111111, 6'b111111};
    logic dir_e[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.data_in = '0;
    bus.out_ready = 1'b0;
    #2;
    check("rst_state", {bus.in_ready, bus.out_valid, bus.err_out, bus.code_out}, 9'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_release_ready", bus.in_ready, 1);
    for (int i = 0; i < 5; i++) begin
      encode(dir_d[i], 0, 1'b0, c, e);
      check("dir_code", c, dir_c[i]);
      check("dir_err", e, dir_e[i]);
    end
    encode(20, 5, 1'b1, c, e);
    check("stall_code", c, 6'b101010);
    for (int d = 0; d <= 32; d++) begin
      encode(d, 0, 1'b0, c, e);
      check("sweep_decode", decode(c), d);
    end
    repeat (20) begin
      int d = $urandom_range(0, 63);
      encode(d, $urandom_range(0, 3), 1'($urandom_range(0, 1)), c, e);
      if (d <= 32) check("rand_decode", decode(c), d);
    end
    @(negedge clk);
    bus.data_in = 6'd20;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_in_reset", {bus.out_valid, bus.in_ready}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("abort_after", {bus.out_valid, bus.in_ready, bus.err_out, bus.code_out}, {2'b01, 7'h0});
    encode(7, 0, 1'b0, c, e);
    check("post_abort_code", c, 6'b001010);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
